// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width for a given operand width: must hold 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Sum of two residues, reduced back into 0..2.
  function automatic logic [1:0] add_mod3(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // x mod 3 by alternating sum: even bit positions weigh +1, odd ones -1 (== 2).
  function automatic logic [1:0] mod3(input logic [63:0] x);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < 64; k++) begin
      if (x[k]) r = add_mod3(r, ((k % 2) == 0) ? 2'd1 : 2'd2);
    end
    return r;
  endfunction

  // Residue of the product of two residues.
  function automatic logic [1:0] mul_mod3(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] m;
    m = {2'b00, x} * {2'b00, y};
    return mod3(64'(m));
  endfunction

endpackage

// File: rtl/mult_unsigned_seq_chk_mod3.sv
// Combinational mod-3 residue of a W-bit unsigned value.
module mod3_residue
  import mult_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_x,
  output logic [1:0]   o_r
);

  assign o_r = mod3(64'(i_x));

endmodule

// File: rtl/mult_unsigned_seq_chk.sv
// Radix-2 shift-add unsigned multiplier, WIDTH cycles per product, with a
// concurrent mod-3 residue check on the result.
module mult_unsigned_seq_chk
  import mult_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               fault,
  output logic               fault_sticky,
  output logic               busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_mcand;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mpl_nxt;
  logic             w_last;
  logic             w_accept;
  logic             w_done_entry;
  logic             w_release;

  // One shift-add step: conditional add into the high half, carry kept,
  // then {carry, acc, mplier} shifts right by one.
  assign w_sum        = r_mplier[0] ? ({1'b0, r_acc} + {1'b0, r_mcand}) : {1'b0, r_acc};
  assign w_acc_nxt    = w_sum[WIDTH:1];
  assign w_mpl_nxt    = {w_sum[0], r_mplier[WIDTH-1:1]};
  assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept     = (r_state == IDLE) && in_valid;
  assign w_done_entry = (r_state == RUN) && w_last;
  assign w_release    = (r_state == DONE) && out_ready;

  // Control FSM plus the shift-add datapath; no early exit on zero operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= w_mpl_nxt;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign p         = {r_acc, r_mplier};

  generate
    if (CHECK_EN) begin : g_chk
      logic [1:0] w_ra_in;
      logic [1:0] w_rb_in;
      logic [1:0] w_rp_nxt;
      logic [1:0] r_ra;
      logic [1:0] r_rb;
      logic       r_fault;
      logic       r_sticky;
      logic       w_mismatch;

      mod3_residue #(.W(WIDTH))   u_res_a (.i_x(a),                      .o_r(w_ra_in));
      mod3_residue #(.W(WIDTH))   u_res_b (.i_x(b),                      .o_r(w_rb_in));
      mod3_residue #(.W(2*WIDTH)) u_res_p (.i_x({w_acc_nxt, w_mpl_nxt}), .o_r(w_rp_nxt));

      // Compare against the product being written on the DONE-entry edge so
      // the verdict lands in the same cycle as out_valid.
      assign w_mismatch = (mul_mod3(r_ra, r_rb) != w_rp_nxt);

      // Operand residues captured at accept; fault/sticky updated at DONE entry.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ra     <= 2'd0;
          r_rb     <= 2'd0;
          r_fault  <= 1'b0;
          r_sticky <= 1'b0;
        end else begin
          if (w_accept) begin
            r_ra <= w_ra_in;
            r_rb <= w_rb_in;
          end
          if (w_done_entry) begin
            r_fault  <= w_mismatch;
            r_sticky <= r_sticky | w_mismatch;
          end else if (w_release) begin
            r_fault <= 1'b0;
          end
        end
      end

      assign fault        = r_fault;
      assign fault_sticky = r_sticky;
    end else begin : g_nochk
      assign fault        = 1'b0;
      assign fault_sticky = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_mult_unsigned_seq_chk.sv
// Scoreboard bench for mult_unsigned_seq_chk (WIDTH=4 checked, WIDTH=8 unchecked).
module tb_mult_unsigned_seq_chk;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  p;
  logic        fault;
  logic        fault_sticky;
  logic        busy;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        out_valid8;
  logic        out_ready8;
  logic [15:0] p8;
  logic        fault8;
  logic        sticky8;
  logic        busy8;

  typedef struct {
    logic [7:0] p;
    logic       f;
    int         t;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   n_rise  = 0;
  logic prev_ov = 1'b0;
  logic f8_seen = 1'b0;

  mult_unsigned_seq_chk #(.WIDTH(4), .CHECK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .fault(fault), .fault_sticky(fault_sticky), .busy(busy)
  );

  mult_unsigned_seq_chk #(.WIDTH(8), .CHECK_EN(1'b0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .p(p8), .fault(fault8), .fault_sticky(sticky8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] ta, input logic [3:0] tbv,
                       input logic [7:0] ep, input logic ef, output int t);
    int   n;
    exp_t e;
    a = ta;
    b = tbv;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t = cyc;
    e.p = ep;
    e.f = ef;
    e.t = cyc;
    q.push_back(e);
  endtask

  // Wait until all expected results are consumed and the block is idle.
  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((q.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: latency at out_valid rise, product/fault at handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          n_rise++;
          check_eq("out_expected", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) check_eq("latency", 64'(cyc - q[0].t), 64'd4);
        end
        if (out_valid && out_ready && q.size() != 0) begin
          e = q.pop_front();
          check_eq("p", 64'(p), 64'(e.p));
          check_eq("fault", 64'(fault), 64'(e.f));
        end
        prev_ov = out_valid;
      end
      if (fault8 || sticky8) f8_seen = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   t0, t1, t2, t8, n, rise_snap;
    logic [3:0] flip;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_p", 64'(p), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_fault", 64'(fault), 64'd0);
    check_eq("rst_sticky", 64'(fault_sticky), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 3*5, in_ready low through RUN and DONE
    issue(4'd3, 4'd5, 8'h0F, 1'b0, t0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t1_in_ready", 64'(in_ready), 64'd0);
      check_eq("t1_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    check_eq("t1_ov_low", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // max operands then zero, back to back
    issue(4'd15, 4'd15, 8'hE1, 1'b0, t1);
    issue(4'd0, 4'd9, 8'h00, 1'b0, t2);
    check_eq("init_interval", 64'(t2 - t1), 64'd6);
    drain();

    // backpressure
    out_ready = 1'b0;
    issue(4'd7, 4'd6, 8'd42, 1'b0, t0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check_eq("bp_ov", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b1; a = 4'd1; b = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_p_hold", 64'(p), 64'd42);
      check_eq("bp_ov_hold", 64'(out_valid), 64'd1);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_idle_busy", 64'(busy), 64'd0);
    check_eq("bp_idle_ready", 64'(in_ready), 64'd1);
    check_eq("bp_ov_fell", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // bit flip in acc during RUN: 5*3 becomes 17, residue mismatch
    issue(4'd5, 4'd3, 8'd17, 1'b1, t0);
    @(posedge clk);
    #2;
    flip = dut.r_acc ^ 4'b0001;
    force dut.r_acc = flip;
    #1 release dut.r_acc;
    drain();
    check_eq("sticky_set", 64'(fault_sticky), 64'd1);
    issue(4'd2, 4'd3, 8'd6, 1'b0, t0);
    drain();
    check_eq("sticky_persist", 64'(fault_sticky), 64'd1);

    // asynchronous reset mid-RUN
    issue(4'd9, 4'd9, 8'd81, 1'b0, t0);
    rise_snap = n_rise;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("mr_in_ready", 64'(in_ready), 64'd1);
    check_eq("mr_busy", 64'(busy), 64'd0);
    check_eq("mr_out_valid", 64'(out_valid), 64'd0);
    check_eq("mr_p", 64'(p), 64'd0);
    check_eq("mr_fault", 64'(fault), 64'd0);
    check_eq("mr_sticky", 64'(fault_sticky), 64'd0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("mr_no_out", 64'(n_rise), 64'(rise_snap));
    @(posedge clk); #1;
    issue(4'd2, 4'd2, 8'd4, 1'b0, t0);
    drain();

    // WIDTH=8 without checker
    in_valid8 = 1'b1; a8 = 8'd255; b8 = 8'd255;
    @(negedge clk);
    check_eq("w8_in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    t8 = cyc;
    n = 0;
    @(negedge clk);
    while (!out_valid8 && n < 30) begin @(negedge clk); n++; end
    check_eq("w8_ov", 64'(out_valid8), 64'd1);
    check_eq("w8_latency", 64'(cyc - t8), 64'd8);
    check_eq("w8_p", 64'(p8), 64'd65025);
    check_eq("w8_busy", 64'(busy8), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("w8_ov_fell", 64'(out_valid8), 64'd0);
    check_eq("w8_fault_never", 64'(f8_seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
